// File: rtl/crc32_stream_engine.sv
// rtl/crc32_stream_engine.sv - streaming CRC-32 engine with valid/ready word input and registered result port
// Optional final XOR mask enabled by defining CRC32_FINAL_XOR_EN.
`timescale 1ns/1ps

module crc32_comb (
   input  logic [31:0] crcIn,
   input  logic [31:0] data,
   output logic [31:0] crcOut
);
   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic [31:0] work;

   // Word width equals CRC width, so feeding data MSB-first reduces to shifting crcIn ^ data.
   always_comb begin
      work = crcIn ^ data;
      for (int i = 0; i < 32; i++) begin
         work = work[31] ? ({work[30:0], 1'b0} ^ POLY) : {work[30:0], 1'b0};
      end
      crcOut = work;
   end
endmodule

module crc32_stream_engine #(
   parameter logic [31:0] INIT_VALUE = 32'hFFFF_FFFF,
   parameter logic [31:0] XOR_OUT    = 32'hFFFF_FFFF,
   parameter int          CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             abort,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [31:0]      s_data,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [31:0]      m_crc,
   output logic [CNT_W-1:0] m_words,
   output logic             busy
);
   typedef enum logic {IDLE, ACCUM} state_t;

   state_t           stateQ;
   logic [31:0]      crcQ;
   logic [31:0]      nxtCrc;
   logic [31:0]      finCrc;
   logic [CNT_W-1:0] cntQ;
   logic [CNT_W-1:0] cntInc;
   logic             acc;

   crc32_comb uCrc (
      .crcIn  (crcQ),
      .data   (s_data),
      .crcOut (nxtCrc)
   );

`ifdef CRC32_FINAL_XOR_EN
   assign finCrc = nxtCrc ^ XOR_OUT;
`else
   localparam logic [31:0] unusedXorOut = XOR_OUT;
   assign finCrc = nxtCrc;
`endif

   assign s_ready = !m_valid || m_ready;
   assign acc     = s_valid && s_ready && !abort;
   assign cntInc  = (&cntQ) ? cntQ : cntQ + 1'b1;
   assign busy    = (stateQ == ACCUM);

   // cntQ is zero in IDLE, so cntInc also yields the 1-word count there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ  <= IDLE;
         crcQ    <= INIT_VALUE;
         cntQ    <= '0;
         m_valid <= 1'b0;
         m_crc   <= '0;
         m_words <= '0;
      end else begin
         if (abort) begin
            stateQ <= IDLE;
            crcQ   <= INIT_VALUE;
            cntQ   <= '0;
         end else if (acc) begin
            if (s_last) begin
               stateQ <= IDLE;
               crcQ   <= INIT_VALUE;
               cntQ   <= '0;
            end else begin
               stateQ <= ACCUM;
               crcQ   <= nxtCrc;
               cntQ   <= cntInc;
            end
         end

         // Result register runs beside the FSM; a new load wins over the consume.
         if (acc && s_last) begin
            m_valid <= 1'b1;
            m_crc   <= finCrc;
            m_words <= cntInc;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end
endmodule
